// File: rtl/systolic_tile_sequencer.sv
// Weight-stationary tile sequencer for an S x S systolic array: loads weights, skews activations,
// de-skews bottom-row partial sums. Optional perf counters under STRAIT_SEQ_PERF_CNT_EN.
module systolic_tile_sequencer #(
   parameter int unsigned SYSTOLIC_SIZE     = 8,
   parameter int unsigned WEIGHT_WIDTH      = 8,
   parameter int unsigned ACTIVATION_WIDTH  = 8,
   parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH +
                                              $clog2(SYSTOLIC_SIZE),
   parameter int unsigned MAX_VECTORS       = 256,
   localparam int unsigned VCW              = $clog2(MAX_VECTORS + 1)
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        start_i,
   input  logic [VCW-1:0]                              num_vectors_i,
   input  logic [SYSTOLIC_SIZE-1:0]                    pe_disable_cfg_i,
   output logic                                        busy_o,
   output logic                                        done_o,
   input  logic                                        w_valid_i,
   output logic                                        w_ready_o,
   input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]       w_data_i,
   input  logic                                        a_valid_i,
   output logic                                        a_ready_o,
   input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   a_data_i,
   output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]       arr_weight_flat_o,
   output logic                                        arr_weight_shift_o,
   output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   arr_act_flat_o,
   output logic [SYSTOLIC_SIZE-1:0]                    arr_pe_disable_o,
   output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]  arr_psum_in_flat_o,
   input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]  arr_psum_flat_i,
`ifdef STRAIT_SEQ_PERF_CNT_EN
   output logic [31:0]                                 perf_cycles_o,
   output logic [31:0]                                 perf_bubbles_o,
`endif
   output logic                                        r_valid_o,
   output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]  r_data_o
);

   localparam int unsigned S       = SYSTOLIC_SIZE;
   localparam int unsigned AW      = ACTIVATION_WIDTH;
   localparam int unsigned PSW     = PARTIAL_SUM_WIDTH;
   localparam int unsigned WCW     = $clog2(SYSTOLIC_SIZE);
   localparam int unsigned LATENCY = 2 * SYSTOLIC_SIZE + 1;

   typedef enum logic [2:0] {StIdle, StLoadW, StCompute, StDrain, StDone} state_e;

   state_e                       state_q;
   logic                         busy_q, done_q, w_ready_q, a_ready_q, shift_q;
   logic [S*WEIGHT_WIDTH-1:0]    weight_q;
   logic [S-1:0]                 pe_dis_q;
   logic [WCW-1:0]               wcnt_q;
   logic [VCW-1:0]               vcnt_q, nvec_q;
   logic [LATENCY-1:0]           tag_q;

   logic w_fire, a_fire, start_acc;

   assign w_fire    = w_valid_i & w_ready_q;
   assign a_fire    = a_valid_i & a_ready_q;
   assign start_acc = (state_q == StIdle) && start_i && (num_vectors_i != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         w_ready_q <= 1'b0;
         a_ready_q <= 1'b0;
         shift_q   <= 1'b0;
         weight_q  <= '0;
         pe_dis_q  <= '0;
         wcnt_q    <= '0;
         vcnt_q    <= '0;
         nvec_q    <= '0;
      end else begin
         done_q  <= 1'b0;
         shift_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_acc) begin
                  state_q   <= StLoadW;
                  busy_q    <= 1'b1;
                  w_ready_q <= 1'b1;
                  nvec_q    <= num_vectors_i;
                  pe_dis_q  <= pe_disable_cfg_i;
                  wcnt_q    <= '0;
                  vcnt_q    <= '0;
               end
            end
            StLoadW: begin
               if (w_fire) begin
                  weight_q <= w_data_i;
                  shift_q  <= 1'b1;
                  if (wcnt_q == WCW'(S - 1)) begin
                     wcnt_q    <= '0;
                     w_ready_q <= 1'b0;
                     a_ready_q <= 1'b1;
                     state_q   <= StCompute;
                  end else begin
                     wcnt_q <= wcnt_q + WCW'(1);
                  end
               end
            end
            StCompute: begin
               if (a_fire) begin
                  vcnt_q <= vcnt_q + VCW'(1);
                  if (vcnt_q == nvec_q - VCW'(1)) begin
                     a_ready_q <= 1'b0;
                     state_q   <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (tag_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Tag travels alongside each vector so r_valid lines up with its de-skewed sum.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tag_q <= '0;
      else       tag_q <= {tag_q[LATENCY-2:0], a_fire};
   end

   for (genvar i = 0; i < S; i++) begin : g_skew
      logic [i:0][AW-1:0] sr_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sr_q <= '0;
         end else begin
            sr_q[0] <= a_fire ? a_data_i[i*AW +: AW] : '0;
            for (int k = 1; k <= i; k++) sr_q[k] <= sr_q[k-1];
         end
      end
      assign arr_act_flat_o[i*AW +: AW] = sr_q[i];
   end

   for (genvar j = 0; j < S; j++) begin : g_col
      logic [PSW-1:0] col_dly;
      logic [PSW-1:0] r_q;
      if (j == S - 1) begin : g_nodly
         assign col_dly = arr_psum_flat_i[j*PSW +: PSW];
      end else begin : g_dly
         logic [S-2-j:0][PSW-1:0] d_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               d_q <= '0;
            end else begin
               d_q[0] <= arr_psum_flat_i[j*PSW +: PSW];
               for (int k = 1; k < S - 1 - j; k++) d_q[k] <= d_q[k-1];
            end
         end
         assign col_dly = d_q[S-2-j];
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) r_q <= '0;
         else       r_q <= tag_q[LATENCY-2] ? col_dly : '0;
      end
      assign r_data_o[j*PSW +: PSW] = r_q;
   end

`ifdef STRAIT_SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles_q, perf_bubbles_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_cycles_q  <= '0;
         perf_bubbles_q <= '0;
      end else if (start_acc) begin
         perf_cycles_q  <= '0;
         perf_bubbles_q <= '0;
      end else begin
         if (busy_q && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 32'd1;
         if ((state_q == StCompute) && !a_fire && !(&perf_bubbles_q)) begin
            perf_bubbles_q <= perf_bubbles_q + 32'd1;
         end
      end
   end
   assign perf_cycles_o  = perf_cycles_q;
   assign perf_bubbles_o = perf_bubbles_q;
`endif

   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign w_ready_o          = w_ready_q;
   assign a_ready_o          = a_ready_q;
   assign arr_weight_flat_o  = weight_q;
   assign arr_weight_shift_o = shift_q;
   assign arr_pe_disable_o   = pe_dis_q;
   assign arr_psum_in_flat_o = '0;
   assign r_valid_o          = tag_q[LATENCY-1];

endmodule
